// File: rtl/dlfloat_pkg.sv
// Shared constants, DLFloat16 field layout and control-pin indices for the dlfloat_mac core.
package dlfloat_pkg;

   localparam int BIAS   = 31;
   localparam int EXP_W  = 6;
   localparam int FRAC_W = 9;

   localparam logic [15:0] DLF_NAN  = 16'h7FFF;
   localparam logic [15:0] DLF_ZERO = 16'h0000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } dlf_t;

   // uio_in bit positions
   localparam int CTL_WR    = 0;
   localparam int CTL_ADDR  = 1;
   localparam int CTL_START = 3;
   localparam int CTL_CLEAR = 4;
   localparam int CTL_RDSEL = 5;

   // Leading-zero count over the 17-bit adder window; 17 when the value is zero.
   function automatic logic [4:0] lzc17(input logic [16:0] v);
      lzc17 = 5'd17;
      for (int i = 0; i <= 16; i++)
         if (v[i]) lzc17 = 5'(16 - i);
   endfunction

endpackage

// File: rtl/dlfloat_fma_dp.sv
// Fused datapath: combinational 10x10 multiply into a product register, then
// combinational align/add/normalize/round against the accumulator.
module dlfloat_fma_dp
   import dlfloat_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ld,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   input  logic [15:0] acc,
   output logic [15:0] res,
   output logic        ovf,
   output logic        unf,
   output logic        nan
);
   localparam logic signed [9:0] BIAS_S = 10'(BIAS);
   localparam logic signed [9:0] ZEXP   = -10'sd64;

   dlf_t fa, fb, fc;
   assign fa = dlf_t'(op_a);
   assign fb = dlf_t'(op_b);
   assign fc = dlf_t'(acc);

   logic [19:0]       prod;
   logic signed [9:0] m_exp;
   logic [13:0]       m_sig;
   logic              m_stk, m_zero, m_nan, m_sign;

   always_comb begin
      prod   = 20'({1'b1, fa.frac}) * 20'({1'b1, fb.frac});
      m_exp  = $signed({4'b0, fa.exp}) + $signed({4'b0, fb.exp}) - BIAS_S
               + (prod[19] ? 10'sd1 : 10'sd0);
      m_sig  = prod[19] ? {1'b1, prod[18:6]} : {1'b1, prod[17:5]};
      m_stk  = prod[19] ? |prod[5:0] : |prod[4:0];
      m_zero = (fa.exp == '0) | (fb.exp == '0);
      m_nan  = (op_a == DLF_NAN) | (op_b == DLF_NAN);
      m_sign = fa.sign ^ fb.sign;
   end

   logic signed [9:0] p_exp;
   logic [13:0]       p_sig;
   logic              p_stk, p_zero, p_nan, p_sign;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_exp  <= '0;
         p_sig  <= '0;
         p_stk  <= 1'b0;
         p_zero <= 1'b1;
         p_nan  <= 1'b0;
         p_sign <= 1'b0;
      end else if (ld) begin
         p_exp  <= m_exp;
         p_sig  <= m_sig;
         p_stk  <= m_stk;
         p_zero <= m_zero;
         p_nan  <= m_nan;
         p_sign <= m_sign;
      end
   end

   // Magnitudes carry {sig[13:0], sticky}; zero operands sort below everything.
   logic [14:0]       x_mag, y_mag, big_mag, sml_mag;
   logic signed [9:0] x_exp, y_exp, big_exp, sml_exp, d, er, er2;
   logic              big_sign, sml_sign, swap, g, rest, up, carry;
   logic [16:0]       big_ext, sml_ext, sml_al, mask, norm;
   logic [17:0]       sum;
   logic [4:0]        lz;
   logic [8:0]        frac, frac_r;
   logic              unused_bits;

   always_comb begin
      x_mag = p_zero ? 15'd0 : {p_sig, p_stk};
      x_exp = p_zero ? ZEXP : p_exp;
      y_mag = (fc.exp == '0) ? 15'd0 : {1'b1, fc.frac, 4'b0, 1'b0};
      y_exp = (fc.exp == '0) ? ZEXP : $signed({4'b0, fc.exp});
      swap  = (y_exp > x_exp) || ((y_exp == x_exp) && (y_mag > x_mag));

      big_mag  = swap ? y_mag   : x_mag;
      big_exp  = swap ? y_exp   : x_exp;
      big_sign = swap ? fc.sign : p_sign;
      sml_mag  = swap ? x_mag   : y_mag;
      sml_exp  = swap ? x_exp   : y_exp;
      sml_sign = swap ? p_sign  : fc.sign;

      big_ext = {big_mag[14:1], 2'b00, big_mag[0]};
      sml_ext = {sml_mag[14:1], 2'b00, sml_mag[0]};
      d       = big_exp - sml_exp;
      mask    = '0;
      if (d > 10'sd17) begin
         sml_al = {16'b0, |sml_ext};
      end else begin
         mask   = ~(17'h1FFFF << d[4:0]);
         sml_al = (sml_ext >> d[4:0]) | {16'b0, |(sml_ext & mask)};
      end

      if (big_sign ^ sml_sign) sum = {1'b0, big_ext} - {1'b0, sml_al};
      else                     sum = {1'b0, big_ext} + {1'b0, sml_al};

      lz = lzc17(sum[16:0]);
      if (sum[17]) begin
         norm = {sum[17:2], sum[1] | sum[0]};
         er   = big_exp + 10'sd1;
      end else begin
         norm = sum[16:0] << lz;
         er   = big_exp - $signed({5'b0, lz});
      end

      frac           = norm[15:7];
      g              = norm[6];
      rest           = |norm[5:0];
      up             = g & (rest | frac[0]);
      {carry, frac_r} = {1'b0, frac} + 10'(up);
      er2            = carry ? er + 10'sd1 : er;

      res = DLF_ZERO;
      ovf = 1'b0;
      unf = 1'b0;
      nan = 1'b0;
      if (p_nan || (acc == DLF_NAN)) begin
         res = DLF_NAN;
         nan = 1'b1;
      end else if (sum == '0) begin
         res = DLF_ZERO;
      end else if ((er2 > 10'sd63) || ((er2 == 10'sd63) && (frac_r == 9'h1FF))) begin
         res = DLF_NAN;
         ovf = 1'b1;
      end else if (er2 < 10'sd1) begin
         res = DLF_ZERO;
         unf = 1'b1;
      end else begin
         res = {big_sign, er2[5:0], frac_r};
      end
   end

   assign unused_bits = norm[16];

endmodule

// File: rtl/dlfloat_mac.sv
// DLFloat16 multiply-accumulate core on the byte-wide pin interface: acc <= acc + A*B.
// Define DLFMAC_FLAGS_EN to add sticky overflow/underflow/NaN flags on uio_out[6:4].
module dlfloat_mac
   import dlfloat_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   logic [15:0] a_reg, b_reg, op_a, op_b, acc, res;
   logic [1:0]  vld_pipe;
   logic        busy, wr, start, clr, go;
   logic        ovf, unf, nan;
   logic [2:0]  flags;
   logic        unused_bits;

   assign wr    = ena & uio_in[CTL_WR];
   assign start = ena & uio_in[CTL_START];
   assign clr   = ena & uio_in[CTL_CLEAR];
   assign busy  = |vld_pipe;
   assign go    = start & ~busy & ~clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
      end else if (wr) begin
         case (uio_in[CTL_ADDR +: 2])
            2'd0:    a_reg[7:0]  <= ui_in;
            2'd1:    a_reg[15:8] <= ui_in;
            2'd2:    b_reg[7:0]  <= ui_in;
            default: b_reg[15:8] <= ui_in;
         endcase
      end
   end

   // vld_pipe[0]: operands captured; vld_pipe[1]: product registered, acc retires next edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a     <= '0;
         op_b     <= '0;
         vld_pipe <= '0;
         acc      <= DLF_ZERO;
      end else if (ena) begin
         if (clr) begin
            vld_pipe <= '0;
            acc      <= DLF_ZERO;
         end else begin
            vld_pipe <= {vld_pipe[0], go};
            if (go) begin
               op_a <= a_reg;
               op_b <= b_reg;
            end
            if (vld_pipe[1]) acc <= res;
         end
      end
   end

   dlfloat_fma_dp u_dp (
      .clk  (clk),
      .rst  (rst),
      .ld   (vld_pipe[0] & ena),
      .op_a (op_a),
      .op_b (op_b),
      .acc  (acc),
      .res  (res),
      .ovf  (ovf),
      .unf  (unf),
      .nan  (nan)
   );

`ifdef DLFMAC_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  flags <= '0;
      else if (ena) begin
         if (clr)               flags <= '0;
         else if (vld_pipe[1])  flags <= flags | {ovf, unf, nan};
      end
   end
   assign uio_oe      = 8'hF0;
   assign unused_bits = &{1'b0, uio_in[7:6]};
`else
   assign flags       = 3'b000;
   assign uio_oe      = 8'h80;
   assign unused_bits = &{1'b0, uio_in[7:6], ovf, unf, nan};
`endif

   assign uo_out  = uio_in[CTL_RDSEL] ? acc[15:8] : acc[7:0];
   assign uio_out = {busy, flags, 4'b0000};

endmodule

// File: tb/tb_dlfloat_mac.sv
// Directed bench for dlfloat_mac: hand-computed DLFloat16 MAC vectors, busy/clear/reset timing.
module tb_dlfloat_mac;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uo_out, uio_out, uio_oe;
   logic       wr = 1'b0, start = 1'b0, clr = 1'b0, rsel = 1'b0;
   logic [1:0] waddr = 2'd0;
   logic [7:0] uio_in;
   int         checks = 0;
   int         failures = 0;
   logic [15:0] rd;

   assign uio_in = {2'b00, rsel, clr, start, waddr, wr};

   dlfloat_mac dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic read_acc(output logic [15:0] v);
      rsel = 1'b0; #1 v[7:0] = uo_out;
      rsel = 1'b1; #1 v[15:8] = uo_out;
      rsel = 1'b0;
   endtask

   task automatic wr_byte(input logic [1:0] a, input logic [7:0] d);
      wr = 1'b1; waddr = a; ui_in = d;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic load(input logic [15:0] a, input logic [15:0] b);
      wr_byte(2'd0, a[7:0]);
      wr_byte(2'd1, a[15:8]);
      wr_byte(2'd2, b[7:0]);
      wr_byte(2'd3, b[15:8]);
   endtask

   task automatic pulse_clear;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   // Start, then check busy across both pipeline cycles and the retired accumulator.
   task automatic run_op(input string tag, input logic [15:0] exp);
      logic [15:0] v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy1"}, 16'(uio_out[7]), 16'd1);
      @(negedge clk);
      chk({tag, "_busy2"}, 16'(uio_out[7]), 16'd1);
      @(negedge clk);
      chk({tag, "_busy0"}, 16'(uio_out[7]), 16'd0);
      read_acc(v);
      chk({tag, "_acc"}, v, exp);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      read_acc(rd);
      chk("reset_acc", rd, 16'h0000);
      chk("reset_status", 16'(uio_out), 16'h0000);
`ifdef DLFMAC_FLAGS_EN
      chk("reset_oe", 16'(uio_oe), 16'h00F0);
`else
      chk("reset_oe", 16'(uio_oe), 16'h0080);
`endif
      rst = 1'b0;
      @(negedge clk);

      pulse_clear();
      load(16'h3F00, 16'h4000);
      run_op("mac_1p5x2", 16'h4100);
      run_op("mac_repeat", 16'h4300);

      pulse_clear();
      run_op("mac_again", 16'h4100);
      load(16'hBF00, 16'h4000);
      run_op("cancel", 16'h0000);
      load(16'hBE00, 16'h4100);
      run_op("neg3", 16'hC100);

      pulse_clear();
      load(16'h7E00, 16'h7E00);
      run_op("overflow", 16'h7FFF);
`ifdef DLFMAC_FLAGS_EN
      chk("flag_ovf", 16'(uio_out[6]), 16'd1);
`endif
      load(16'h3E00, 16'h3E00);
      run_op("nan_sticky", 16'h7FFF);
      pulse_clear();
      read_acc(rd);
      chk("clear_acc", rd, 16'h0000);
`ifdef DLFMAC_FLAGS_EN
      chk("flag_clr", 16'(uio_out[6]), 16'd0);
`endif
      load(16'h7FFF, 16'h0000);
      run_op("nan_x_zero", 16'h7FFF);

      // Second start one cycle later must be ignored while busy.
      pulse_clear();
      load(16'h3F00, 16'h4000);
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      read_acc(rd);
      chk("double_start", rd, 16'h4100);
      chk("double_busy", 16'(uio_out[7]), 16'd0);

      // Clear on edge N+1 cancels the in-flight product.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      read_acc(rd);
      chk("clr_mid_acc", rd, 16'h0000);
      chk("clr_mid_busy", 16'(uio_out[7]), 16'd0);
      @(negedge clk);
      read_acc(rd);
      chk("clr_mid_after", rd, 16'h0000);

      // ena low: start ignored.
      ena = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ena_off_busy", 16'(uio_out[7]), 16'd0);
      ena = 1'b1;

      // Async reset between N and N+2.
      run_op("pre_rst", 16'h4100);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #2 rst = 1'b1;
      #1;
      read_acc(rd);
      chk("async_rst_acc", rd, 16'h0000);
      chk("async_rst_busy", 16'(uio_out[7]), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      read_acc(rd);
      chk("post_rst_acc", rd, 16'h0000);
      chk("post_rst_busy", 16'(uio_out[7]), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
